rriot_timer: RTL

RRIOT_TIMER -- requirements
Module: rriot_timer

---
 rtl/rriot_pkg.sv | 37 +++
 rtl/rriot_prescaler.sv | 41 ++++
 rtl/rriot_timer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rriot_pkg.sv
// rriot_pkg
//   Shared definitions for the RRIOT interval timer:
//   - div_e        : divider select as written through addr[1:0]
//   - IRQ_EN_BIT   : address bit carrying the interrupt-enable on writes/timer reads
//   - FLAG_SEL_BIT : address bit selecting flag (1) or count (0) on reads
//   - TERM_*       : prescaler terminal values (N-1) for each divider
//   - div_terminal : maps a divider select to its terminal value
package rriot_pkg;

    typedef enum logic [1:0] {
        DIV1    = 2'b00,
        DIV8    = 2'b01,
        DIV64   = 2'b10,
        DIV1024 = 2'b11
    } div_e;

    localparam int unsigned IRQ_EN_BIT   = 3;
    localparam int unsigned FLAG_SEL_BIT = 0;

    localparam logic [9:0] TERM_DIV1    = 10'd0;
    localparam logic [9:0] TERM_DIV8    = 10'd7;
    localparam logic [9:0] TERM_DIV64   = 10'd63;
    localparam logic [9:0] TERM_DIV1024 = 10'd1023;

    function automatic logic [9:0] div_terminal(input div_e d);
        logic [9:0] t;
        case (d)
            DIV1:    t = TERM_DIV1;
            DIV8:    t = TERM_DIV8;
            DIV64:   t = TERM_DIV64;
            DIV1024: t = TERM_DIV1024;
            default: t = TERM_DIV1024;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/rriot_prescaler.sv
// rriot_prescaler
//   10-bit prescale counter for the RRIOT timer. Counts phi2 cycles and
//   pulses tick on the cycle where the count equals the divider's N-1,
//   wrapping to 0 on that edge. With DIV1 the count sits at 0 and tick is
//   high every cycle.
// Ports:
//   phi2  in  clock, rising edge
//   rst   in  asynchronous active-high reset (prescale -> 0)
//   clear in  hold prescale at 0 and suppress tick (write or fast mode)
//   div   in  divider select
//   tick  out combinational terminal-count pulse
module rriot_prescaler
    import rriot_pkg::*;
(
    input  logic phi2,
    input  logic rst,
    input  logic clear,
    input  div_e div,
    output logic tick
);

    logic [9:0] prescale_q;
    logic [9:0] prescale_d;

    always_comb begin
        tick       = !clear && (prescale_q == div_terminal(div));
        prescale_d = prescale_q + 10'd1;
        if (clear || tick) begin
            prescale_d = '0;
        end
    end

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_d;
        end
    end

endmodule

// File: rtl/rriot_timer.sv
// rriot_timer
//   RRIOT-style interval timer. An 8-bit down counter decremented on
//   prescaler ticks; on underflow (0x00 -> 0xFF) it raises flag and enters
//   fast mode, decrementing every cycle until the next write.
// Ports:
//   phi2   in  clock, rising edge
//   rst    in  asynchronous active-high reset
//   sel    in  timer register space selected this cycle
//   we_n   in  0 = write, 1 = read (qualified by sel)
//   addr   in  [3] irq enable, [1:0] divider on write, [0] flag/count on read
//   di     in  write data
//   dout   out combinational read data, 0x00 unless reading
//   irq_n  out active-low interrupt (flag && irq_en)
//   irq_en out current interrupt-enable bit
module rriot_timer
    import rriot_pkg::*;
(
    input  logic       phi2,
    input  logic       rst,
    input  logic       sel,
    input  logic       we_n,
    input  logic [3:0] addr,
    input  logic [7:0] di,
    output logic [7:0] dout,
    output logic       irq_n,
    output logic       irq_en
);

    logic [7:0] count_q,  count_d;
    div_e       div_q,    div_d;
    logic       flag_q,   flag_d;
    logic       irq_en_q, irq_en_d;
    logic       fast_q,   fast_d;

    logic wr;
    logic rd_timer;
    logic rd_flag;
    logic presc_clear;
    logic tick;
    logic dec;
    logic underflow;
    logic unused_addr_bit;

    assign unused_addr_bit = addr[2];

    assign wr       = sel && !we_n;
    assign rd_timer = sel &&  we_n && !addr[FLAG_SEL_BIT];
    assign rd_flag  = sel &&  we_n &&  addr[FLAG_SEL_BIT];

    // Prescale is irrelevant in fast mode; holding it cleared there means a
    // later write always restarts it from 0 without extra state.
    assign presc_clear = wr || fast_q;

    rriot_prescaler u_prescaler (
        .phi2  (phi2),
        .rst   (rst),
        .clear (presc_clear),
        .div   (div_q),
        .tick  (tick)
    );

    assign dec       = !wr && (fast_q || tick);
    assign underflow = dec && (count_q == 8'h00);

    always_comb begin
        count_d  = count_q;
        div_d    = div_q;
        flag_d   = flag_q;
        irq_en_d = irq_en_q;
        fast_d   = fast_q;

        if (wr) begin
            count_d  = di;
            div_d    = div_e'(addr[1:0]);
            irq_en_d = addr[IRQ_EN_BIT];
            flag_d   = 1'b0;
            fast_d   = 1'b0;
        end else begin
            if (dec) begin
                count_d = count_q - 8'd1;
            end
            if (rd_timer) begin
                irq_en_d = addr[IRQ_EN_BIT];
                flag_d   = 1'b0;
            end
            // Set after clear so a coinciding underflow keeps the flag.
            if (underflow) begin
                flag_d = 1'b1;
                fast_d = 1'b1;
            end
        end
    end

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            count_q  <= 8'hFF;
            div_q    <= DIV1024;
            flag_q   <= 1'b0;
            irq_en_q <= 1'b0;
            fast_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            div_q    <= div_d;
            flag_q   <= flag_d;
            irq_en_q <= irq_en_d;
            fast_q   <= fast_d;
        end
    end

    always_comb begin
        dout = '0;
        if (rd_timer) begin
            dout = count_q;
        end else if (rd_flag) begin
            dout = {flag_q, 7'b0};
        end
    end

    assign irq_n  = !(flag_q && irq_en_q);
    assign irq_en = irq_en_q;

endmodule
